regfile_snapshot_streamer: RTL and testbench
============================================

Name: regfile_snapshot_streamer

Overview:
Debug stage directly downstream of the processor register file. On a snapshot request it freezes the processor, then streams one frame out of a valid/ready port: a header word, the captured PC (instruction-memory address) and registers FIRST_REG..FIRST_REG+NUM_REGS-1 read through a dedicated regfile read port. A host-side dumper or on-chip trace buffer consumes the frame, so register contents can be checked in hardware without simulator hierarchy probes.

Parameters:
NUM_REGS, 29, number of registers streamed per frame (1..31)
FIRST_REG, 1, index of the first register streamed; FIRST_REG+NUM_REGS-1 must be at most 31
HDR_TAG, 16'hE260, constant in header bits [31:16]

Ports:
clock  in  1  system clock, rising-edge
ctrl_reset  in  1  asynchronous, active-high reset
snap_req  in  1  single-cycle snapshot request pulse
pc_in  in  32  current processor fetch address
rd_addr  out  5  regfile debug read-port address
rd_data  in  32  regfile debug read data, combinational from rd_addr
stall_req  out  1  freezes processor PC and register writes
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer accepts the word this cycle
out_data  out  32  stream word
out_last  out  1  marks the final word of a frame
busy  out  1  a frame is in progress
snap_overflow  out  1  sticky flag: a request was dropped

Behaviour:
- Reset (async, immediate): state IDLE. out_valid, out_last, stall_req, busy, snap_overflow = 0. out_data = 0. rd_addr = FIRST_REG. Frame counter = 0. Pending flag = 0.
- States: IDLE, HDR, PCW, REG.
- IDLE: on a clock edge with snap_req=1 or pending=1:
  - capture pc_in into pc_reg.
  - out_data = {HDR_TAG, frame_cnt[7:0], NUM_REGS[7:0]}.
  - out_valid = 1, stall_req = 1, busy = 1, rd_addr = FIRST_REG.
  - go to HDR. pending clears.
- Latency: header is valid on the edge that samples snap_req, so out_valid is visible one cycle after the request cycle.
- Transfer: a word transfers on any edge with out_valid && out_ready. While out_valid=1 and out_ready=0, out_data, out_last and state hold unchanged.
- HDR: on transfer, out_data = pc_reg, go to PCW.
- PCW: on transfer, out_data = rd_data (reg FIRST_REG), rd_addr += 1, go to REG. out_last = 1 if NUM_REGS == 1.
- REG: on transfer with out_last = 0:
  - out_data = rd_data, rd_addr += 1.
  - out_last = 1 when the loaded register is FIRST_REG+NUM_REGS-1.
- REG: on transfer with out_last = 1:
  - out_valid, out_last, stall_req, busy = 0.
  - frame_cnt += 1, wrapping 255 to 0.
  - rd_addr = FIRST_REG, go to IDLE.
- Frame length is NUM_REGS+2 words. With out_ready held at 1, a frame takes NUM_REGS+2 cycles and stall_req is high for exactly those cycles.
- rd_data is sampled only on transfer edges. Data correctness relies on stall_req freezing the regfile. stall_req rises in the same edge as out_valid.
- snap_req while busy:
  - if pending = 0, set pending = 1.
  - if pending = 1, the request is dropped and snap_overflow is set.
- A pending request starts the next frame on the first edge in IDLE, giving one idle cycle between frames.
- snap_overflow clears only on reset.
- snap_req on the same edge as the final transfer: treated as busy, so it sets pending.
- Reset mid-frame aborts the frame immediately: out_valid and stall_req drop asynchronously, the frame counter returns to 0 and no partial tail is sent.

Test Plan:
1. Reset, then pulse snap_req with pc_in=32'h0000_0040, regs 1..29 = index*3, out_ready=1 → 31 words: 32'hE260_001D, 32'h0000_0040, 3, 6, …, 87. out_last is set on the 31st word only, and stall_req is high for 31 cycles.
2. Repeat with out_ready toggled 1,0,0,1… → identical word sequence; out_data is stable during every ready-low cycle and no word is duplicated or skipped.
3. Three snap_req pulses during one frame → exactly one extra frame follows, with header 32'hE260_011D after one idle cycle; snap_overflow = 1 and stays 1 until reset.
4. Run 256 back-to-back frames → the header count field walks 00..FF and the 257th frame's header shows 00.
5. Assert ctrl_reset asynchronously mid-REG (between clock edges) → out_valid, stall_req and busy go to 0 immediately. The next snapshot's header count field is 00.
6. Instance with NUM_REGS=1, FIRST_REG=5 and reg5=32'hDEAD_BEEF → 3 words: 32'hE260_0001, PC, 32'hDEAD_BEEF, with out_last set on the third word.

Source files
------------

// File: rtl/regfile_snapshot_streamer.sv
// Freezes the core on a snapshot request and streams header, PC and a register
// window out of a valid/ready port, reading registers via a debug read port.
// Ports:
//   clock, ctrl_reset        : clock, async active-high reset
//   snap_req, pc_in          : snapshot pulse, current fetch address
//   rd_addr, rd_data         : regfile debug read port (data is combinational)
//   stall_req, busy          : processor freeze / frame in progress
//   out_valid, out_ready,
//   out_data, out_last       : frame stream
//   snap_overflow            : sticky, a request was dropped
module regfile_snapshot_streamer #(
  parameter int          NUM_REGS  = 29,
  parameter int          FIRST_REG = 1,
  parameter logic [15:0] HDR_TAG   = 16'hE260
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        snap_req,
  input  logic [31:0] pc_in,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        stall_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        snap_overflow
);

  localparam logic [4:0] FIRST5 = 5'(FIRST_REG);
  localparam logic [4:0] LAST5  = 5'(FIRST_REG + NUM_REGS - 1);
  localparam logic [7:0] NR8    = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PCW,
    REG
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        xfer;
  logic        active;

  assign xfer   = valid_q & out_ready;
  assign active = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    // One request can wait behind the running frame; a second is lost.
    if (active && snap_req) begin
      if (!pend_q) pend_d = 1'b1;
      else         ovf_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (snap_req || pend_q) begin
          pc_d    = pc_in;
          data_d  = {HDR_TAG, cnt_q, NR8};
          valid_d = 1'b1;
          last_d  = 1'b0;
          addr_d  = FIRST5;
          state_d = HDR;
          // a fresh pulse coinciding with a pending start stays queued
          pend_d  = pend_q & snap_req;
        end
      end
      HDR: begin
        if (xfer) begin
          data_d  = pc_q;
          state_d = PCW;
        end
      end
      PCW: begin
        if (xfer) begin
          data_d  = rd_data;
          addr_d  = addr_q + 5'd1;
          last_d  = (NUM_REGS == 1);
          state_d = REG;
        end
      end
      REG: begin
        if (xfer) begin
          if (!last_q) begin
            data_d = rd_data;
            addr_d = addr_q + 5'd1;
            last_d = (addr_q == LAST5);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = cnt_q + 8'd1;
            addr_d  = FIRST5;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= FIRST5;
      pc_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_addr       = addr_q;
  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_last      = last_q;
  assign stall_req     = active;
  assign busy          = active;
  assign snap_overflow = ovf_q;

endmodule

// File: tb/tb_regfile_snapshot_streamer.sv
// Directed bench for regfile_snapshot_streamer: default instance plus a
// single-register instance (NUM_REGS=1, FIRST_REG=5).
module tb_regfile_snapshot_streamer;

  localparam int NR = 29;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        snap_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        stall_req, out_valid, out_last, busy, snap_overflow;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  logic        snap_b = 1'b0;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        stall_b, valid_b, last_b, busy_b, ovf_b;
  logic        ready_b = 1'b0;
  logic [31:0] data_b;

  logic [31:0] regs [32];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign rd_data   = regs[rd_addr];
  assign rd_data_b = (rd_addr_b == 5'd5) ? 32'hDEAD_BEEF : 32'h0;

  regfile_snapshot_streamer dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .snap_req(snap_req),
    .pc_in(pc_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .stall_req(stall_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .snap_overflow(snap_overflow)
  );

  regfile_snapshot_streamer #(.NUM_REGS(1), .FIRST_REG(5)) dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .snap_req(snap_b),
    .pc_in(pc_in), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .stall_req(stall_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .out_last(last_b), .busy(busy_b),
    .snap_overflow(ovf_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset = 1'b1;
    snap_req = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_ovf", {31'd0, snap_overflow}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_addr", {27'd0, rd_addr}, 32'd1);
    ctrl_reset = 1'b0;
    @(negedge clock);
  endtask

  // Starts (pulse or pending) and consumes one frame; returns at the negedge
  // after the final transfer.
  task automatic frame(input logic [31:0] pc, input logic [31:0] pat,
                       input logic [7:0] cnt, input logic pulses,
                       input logic pend, output int stall_cyc);
    int idx, cyc;
    logic hold_v;
    logic [31:0] held, expw;
    idx = 0; cyc = 0; hold_v = 1'b0; held = '0; stall_cyc = 0;
    pc_in = pc;
    if (!pend) snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    chk("hdr_visible", {31'd0, out_valid}, 32'd1);
    while (idx < NR + 2 && cyc < 400) begin
      if (stall_req) stall_cyc++;
      if (out_valid !== 1'b1)
        chk($sformatf("valid_in_frame[%0d]", idx), {31'd0, out_valid}, 32'd1);
      if (hold_v) chk($sformatf("hold[%0d]", idx), out_data, held);
      out_ready = pat[cyc % 32];
      snap_req = pulses && (cyc == 2 || cyc == 5 || cyc == 8);
      if (out_ready) begin
        if (idx == 0)      expw = {16'hE260, cnt, 8'd29};
        else if (idx == 1) expw = pc;
        else               expw = 32'((idx - 1) * 3);
        chk($sformatf("word[%0d]", idx), out_data, expw);
        chk($sformatf("last[%0d]", idx), {31'd0, out_last},
            {31'd0, idx == NR + 1});
        idx++;
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        held = out_data;
      end
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b0;
    snap_req = 1'b0;
    chk("frame_len", idx, NR + 2);
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    chk("end_stall", {31'd0, stall_req}, 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pat;
    logic [7:0]  cnt;
    logic        pulses;
    logic        pend;
    logic        ovf;
  } vec_t;

  vec_t tbl[5];
  int   sc;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);

    tbl[0] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h1234_5678, 32'h9999_9999, 8'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0080, 32'hFFFF_FFFF, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 32'h0000_00C0, 32'hAAAA_AAAA, 8'd2, 1'b0, 1'b0, 1'b1};

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].rst) do_reset();
      frame(tbl[v].pc, tbl[v].pat, tbl[v].cnt, tbl[v].pulses,
            tbl[v].pend, sc);
      if (tbl[v].pat == 32'hFFFF_FFFF)
        chk($sformatf("stall_cycles[%0d]", v), sc, NR + 2);
      chk($sformatf("ovf[%0d]", v), {31'd0, snap_overflow},
          {31'd0, tbl[v].ovf});
    end

    // frame counter wrap over 257 frames
    do_reset();
    for (int k = 0; k < 257; k++)
      frame(32'h100 + 32'(k), 32'hFFFF_FFFF, 8'(k), 1'b0, 1'b0, sc);

    // async reset in the middle of the register section
    pc_in = 32'h0000_0200;
    snap_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    repeat (10) @(negedge clock);
    #2 ctrl_reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    out_ready = 1'b0;
    ctrl_reset = 1'b0;
    @(negedge clock);
    frame(32'h0000_0300, 32'hFFFF_FFFF, 8'd0, 1'b0, 1'b0, sc);

    // single-register instance
    pc_in = 32'h0000_0ABC;
    snap_b = 1'b1;
    ready_b = 1'b1;
    @(negedge clock);
    snap_b = 1'b0;
    chk("b_w0", data_b, 32'hE260_0001);
    chk("b_l0", {31'd0, last_b}, 32'd0);
    chk("b_v0", {31'd0, valid_b}, 32'd1);
    chk("b_s0", {31'd0, stall_b}, 32'd1);
    @(negedge clock);
    chk("b_w1", data_b, 32'h0000_0ABC);
    chk("b_l1", {31'd0, last_b}, 32'd0);
    @(negedge clock);
    chk("b_w2", data_b, 32'hDEAD_BEEF);
    chk("b_l2", {31'd0, last_b}, 32'd1);
    chk("b_s2", {31'd0, stall_b}, 32'd1);
    @(negedge clock);
    chk("b_v3", {31'd0, valid_b}, 32'd0);
    chk("b_s3", {31'd0, stall_b}, 32'd0);
    ready_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
